mlab_sr_ctrl: RTL and testbench

- Sequencing controller for the MLAB-cell storage array (registered write path, combinational read address, registered data out with parity check).
- Turns the array into a programmable-length delay line (circular buffer).
- Generates write/read addresses, write enable and array clock-enable; tracks fill state to qualify output data; counts parity errors reported by the array.
- Sits between the datapath's advance strobe and one storage array instance.

---
 rtl/mlab_sr_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_mlab_sr_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mlab_sr_ctrl.sv
// mlab_sr_ctrl
// -----------------------------------------------------------------------------
// Sequencing controller that turns one MLAB-cell storage array into a
// programmable-length delay line (circular buffer of DEPTH = 1<<ADDR_WIDTH).
// Data presented with the advance strobe in advance k is visible on the
// array's registered dout at advance k+L, for L = 3..DEPTH.
//
// Optional feature: define MLAB_SR_AUTO_FLUSH_EN to add a one-cycle FLUSH
// state. A sampled parity error in RUN then re-primes the delay line.
// Without the macro, parity errors are only counted.
//
// Ports:
//   clk, arst            clock, asynchronous active-high reset
//   start                pulse: leave IDLE and begin filling
//   stop                 pulse: return to IDLE (highest priority)
//   adv                  datapath advance strobe
//   len, len_load        requested delay L and its load strobe
//   parity_err           parity error flag from the array's dout register
//   sr_ena, sr_we        array clock-enable and write enable
//   sr_wraddr            array write address (current write pointer)
//   sr_rdaddr            array read address (write pointer minus L-1)
//   dout_valid           array dout carries valid delayed data
//   cfg_err              last len_load was out of range and got clamped
//   err_sticky, err_cnt  parity error flag and saturating count
// -----------------------------------------------------------------------------
module mlab_sr_ctrl #(
    parameter int ADDR_WIDTH    = 5,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     arst,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     adv,
    input  logic [ADDR_WIDTH:0]      len,
    input  logic                     len_load,
    input  logic                     parity_err,
    output logic                     sr_ena,
    output logic                     sr_we,
    output logic [ADDR_WIDTH-1:0]    sr_wraddr,
    output logic [ADDR_WIDTH-1:0]    sr_rdaddr,
    output logic                     dout_valid,
    output logic                     cfg_err,
    output logic                     err_sticky,
    output logic [ERR_CNT_WIDTH-1:0] err_cnt
);

    localparam int                  DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] L_MIN = (ADDR_WIDTH+1)'(3);
    localparam logic [ADDR_WIDTH:0] L_MAX = (ADDR_WIDTH+1)'(DEPTH);

`ifdef MLAB_SR_AUTO_FLUSH_EN
    typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN, S_FLUSH} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN} state_t;
`endif

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   wp_q;
    logic [ADDR_WIDTH:0]     fill_q;
    logic [ADDR_WIDTH:0]     l_reg;
    logic [ADDR_WIDTH:0]     l_m1;
    logic                    valid_q;

    logic                    start_go;
    logic                    wp_clr, wp_inc;
    logic                    fill_clr, fill_inc;
    logic                    sampled;

    assign l_m1 = l_reg - (ADDR_WIDTH+1)'(1);

    // The error flag from the array belongs to the data of the previous
    // advance, so it is qualified with last cycle's dout_valid.
    assign sampled = adv & valid_q & parity_err;

    // ---------------------------------------------------------------- state register
    // NOTE: clocked processes use non-blocking assignments so every register
    // sees the pre-edge value of every other register.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // ---------------------------------------------------------------- next state / strobes
    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        start_go = 1'b0;
        wp_clr   = 1'b0;
        wp_inc   = 1'b0;
        fill_clr = 1'b0;
        fill_inc = 1'b0;

        if (stop) begin
            state_d = S_IDLE;                    // wp retained
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!len_load && start) begin
                        state_d  = S_FILL;
                        start_go = 1'b1;
                        wp_clr   = 1'b1;
                        fill_clr = 1'b1;
                    end
                end
                S_FILL: begin
                    if (len_load) begin
                        fill_clr = 1'b1;         // restart priming, wp held
                    end else if (adv) begin
                        wp_inc = 1'b1;
                        // The L-th advance of priming completes the delay line.
                        if (fill_q == l_m1) state_d  = S_RUN;
                        else                fill_inc = 1'b1;
                    end
                end
                S_RUN: begin
                    if (len_load) begin
                        state_d  = S_FILL;
                        fill_clr = 1'b1;
`ifdef MLAB_SR_AUTO_FLUSH_EN
                    end else if (sampled) begin
                        state_d = S_FLUSH;       // wp held for this advance
`endif
                    end else if (adv) begin
                        wp_inc = 1'b1;
                    end
                end
`ifdef MLAB_SR_AUTO_FLUSH_EN
                S_FLUSH: begin
                    state_d  = S_FILL;
                    fill_clr = 1'b1;
                end
`endif
                default: state_d = S_IDLE;
            endcase
        end
    end

    // ---------------------------------------------------------------- outputs
    assign sr_we      = (state_q != S_IDLE);
    assign sr_ena     = adv & sr_we;
    assign dout_valid = (state_q == S_RUN);
    assign sr_wraddr  = wp_q;
    // Read trails write by L-1 slots; with L >= 3 the two never coincide.
    assign sr_rdaddr  = wp_q - l_m1[ADDR_WIDTH-1:0];

    // ---------------------------------------------------------------- datapath registers
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            wp_q       <= '0;
            fill_q     <= '0;
            l_reg      <= L_MIN;
            valid_q    <= 1'b0;
            cfg_err    <= 1'b0;
            err_sticky <= 1'b0;
            err_cnt    <= '0;
        end else begin
            if (wp_clr)      wp_q <= '0;
            else if (wp_inc) wp_q <= wp_q + ADDR_WIDTH'(1);

            if (fill_clr)      fill_q <= '0;
            else if (fill_inc) fill_q <= fill_q + (ADDR_WIDTH+1)'(1);

            // Length is latched in every state, even alongside stop.
            if (len_load) begin
                if (len < L_MIN) begin
                    l_reg   <= L_MIN;
                    cfg_err <= 1'b1;
                end else if (len > L_MAX) begin
                    l_reg   <= L_MAX;
                    cfg_err <= 1'b1;
                end else begin
                    l_reg   <= len;
                    cfg_err <= 1'b0;
                end
            end

            valid_q <= dout_valid;

            if (start_go) begin
                err_sticky <= 1'b0;
                err_cnt    <= '0;
            end else if (sampled) begin
                err_sticky <= 1'b1;
                if (err_cnt != '1) err_cnt <= err_cnt + ERR_CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_mlab_sr_ctrl.sv
// tb_mlab_sr_ctrl
// -----------------------------------------------------------------------------
// Self-checking bench for mlab_sr_ctrl in its default build. A small array
// model (write on ena & we, registered read on ena) is driven by the DUT's
// addresses; the reference model describes the delay line in terms of
// "advances since priming began" and checks addresses, flags, counters and
// the delayed data against a history of presented inputs.
// -----------------------------------------------------------------------------
module tb_mlab_sr_ctrl;

    localparam int AW    = 5;
    localparam int DEPTH = 32;

    logic       clk = 1'b0;
    logic       arst, start, stop, adv, len_load, parity_err;
    logic [5:0] len;
    logic       sr_ena, sr_we, dout_valid, cfg_err, err_sticky;
    logic [4:0] sr_wraddr, sr_rdaddr;
    logic [7:0] err_cnt;

    mlab_sr_ctrl #(.ADDR_WIDTH(AW), .ERR_CNT_WIDTH(8)) dut (
        .clk(clk), .arst(arst), .start(start), .stop(stop), .adv(adv),
        .len(len), .len_load(len_load), .parity_err(parity_err),
        .sr_ena(sr_ena), .sr_we(sr_we), .sr_wraddr(sr_wraddr),
        .sr_rdaddr(sr_rdaddr), .dout_valid(dout_valid), .cfg_err(cfg_err),
        .err_sticky(err_sticky), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    // storage array model
    logic [7:0] mem [0:DEPTH-1];
    logic [7:0] dout_q;
    logic [7:0] din;

    // reference model
    bit         m_active;
    int         m_n;        // advances since priming began
    int         m_wp;
    int         m_L;
    bit         m_cfg;
    int         m_cnt;
    bit         m_sticky;
    bit         m_pvalid;
    logic [7:0] hist [0:63];

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int clamp_len(input int l);
        if (l < 3)     return 3;
        if (l > DEPTH) return DEPTH;
        return l;
    endfunction

    task automatic model_reset();
        m_active = 0; m_n = 0; m_wp = 0; m_L = 3; m_cfg = 0;
        m_cnt = 0; m_sticky = 0; m_pvalid = 0;
    endtask

    task automatic apply_reset();
        arst = 1'b1; adv = 1'b1; start = 1'b0; stop = 1'b0;
        len_load = 1'b0; parity_err = 1'b0; len = '0;
        #1;
        check("rst_we",     sr_we,      0);
        check("rst_ena",    sr_ena,     0);
        check("rst_valid",  dout_valid, 0);
        check("rst_wraddr", sr_wraddr,  0);
        check("rst_cnt",    err_cnt,    0);
        check("rst_sticky", err_sticky, 0);
        check("rst_cfg",    cfg_err,    0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        arst = 1'b0;
        adv  = 1'b0;
    endtask

    // One clock: drive at the falling edge, check 1 ns later, then advance
    // the array and reference models across the rising edge.
    task automatic cycle(input logic i_adv, input logic i_start, input logic i_stop,
                         input logic i_ll, input logic [5:0] i_len, input logic i_pe);
        bit         v, sampled, go;
        logic       c_ena, c_we;
        logic [4:0] c_wa, c_ra;
        adv = i_adv; start = i_start; stop = i_stop; len_load = i_ll;
        len = i_len; parity_err = i_pe; din = 8'($urandom);
        #1;
        v = m_active && (m_n >= m_L);
        check("ena",    sr_ena,     32'(i_adv && m_active));
        check("we",     sr_we,      32'(m_active));
        check("valid",  dout_valid, 32'(v));
        check("wraddr", sr_wraddr,  32'(m_wp));
        check("rdaddr", sr_rdaddr,  32'((m_wp - m_L + 1 + DEPTH) % DEPTH));
        check("cfg",    cfg_err,    32'(m_cfg));
        check("sticky", err_sticky, 32'(m_sticky));
        check("cnt",    err_cnt,    32'(m_cnt));
        if (m_active) check("rd_ne_wr", 32'(sr_rdaddr != sr_wraddr), 1);
        if (v)        check("data", dout_q, hist[(m_n - m_L) % 64]);
        c_ena = sr_ena; c_we = sr_we; c_wa = sr_wraddr; c_ra = sr_rdaddr;
        @(posedge clk);
        if (c_ena)         dout_q    = mem[c_ra];
        if (c_ena && c_we) mem[c_wa] = din;

        sampled = i_adv && m_pvalid && i_pe;
        go      = i_start && !m_active && !i_stop && !i_ll;
        if (i_ll) begin
            m_L   = clamp_len(int'(i_len));
            m_cfg = (i_len < 3) || (i_len > DEPTH);
        end
        if (i_stop) begin
            m_active = 0;
        end else if (i_ll) begin
            if (m_active) m_n = 0;
        end else if (go) begin
            m_active = 1; m_wp = 0; m_n = 0;
        end else if (m_active && i_adv) begin
            hist[m_n % 64] = din;
            m_n++;
            m_wp = (m_wp + 1) % DEPTH;
        end
        if (go) begin
            m_cnt = 0; m_sticky = 0;
        end else if (sampled) begin
            m_cnt    = (m_cnt < 255) ? m_cnt + 1 : 255;
            m_sticky = 1;
        end
        m_pvalid = v;
        @(negedge clk);
    endtask

    initial begin
        dout_q = '0;
        din    = '0;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        for (int i = 0; i < 64; i++)    hist[i] = '0;
        @(negedge clk);
        apply_reset();

        // basic delay, L=5, continuous advance across several wraps
        cycle(0, 0, 0, 1, 6'd5, 0);
        cycle(0, 1, 0, 0, 6'd0, 0);
        repeat (80) cycle(1, 0, 0, 0, 6'd0, 0);

        // stalls: 50% advance pattern
        repeat (150) cycle(1'($urandom % 2), 0, 0, 0, 6'd0, 0);

        // length limits: under- and over-range loads while running
        cycle(1, 0, 0, 1, 6'd2, 0);
        check("cfg_low", cfg_err, 1);
        repeat (40) cycle(1'($urandom % 2), 0, 0, 0, 6'd0, 0);
        cycle(1, 0, 0, 1, 6'd40, 0);
        check("cfg_high", cfg_err, 1);
        repeat (120) cycle(1'($urandom_range(0, 3) != 0), 0, 0, 0, 6'd0, 0);
        cycle(1, 0, 0, 1, 6'd8, 0);
        check("cfg_ok", cfg_err, 0);
        repeat (40) cycle(1, 0, 0, 0, 6'd0, 0);

        // parity: restart clears, errors while invalid are ignored
        cycle(0, 0, 1, 0, 6'd0, 0);
        cycle(0, 1, 0, 0, 6'd0, 0);
        repeat (3) cycle(1, 0, 0, 0, 6'd0, 1);
        check("cnt_invalid", err_cnt, 0);
        repeat (10) cycle(1, 0, 0, 0, 6'd0, 0);
        repeat (3) cycle(1, 0, 0, 0, 6'd0, 1);
        check("cnt3",    err_cnt,    3);
        check("sticky3", err_sticky, 1);
        repeat (300) cycle(1, 0, 0, 0, 6'd0, 1);
        check("cnt_sat", err_cnt, 255);
        repeat (100) cycle(1'($urandom % 2), 0, 0, 0, 6'd0, 1'($urandom_range(0, 3) == 0));

        // asynchronous reset in the middle of RUN
        apply_reset();

        // priority: stop with len_load, then start with the new length
        cycle(0, 0, 0, 1, 6'd5, 0);
        cycle(0, 1, 0, 0, 6'd0, 0);
        repeat (20) cycle(1, 0, 0, 0, 6'd0, 0);
        cycle(1, 1, 1, 1, 6'd6, 0);
        check("pri_idle", sr_we, 0);
        cycle(1, 0, 0, 0, 6'd0, 0);
        cycle(0, 1, 0, 0, 6'd0, 0);
        repeat (30) cycle(1, 0, 0, 0, 6'd0, 0);

        // mixed random control traffic
        repeat (400) cycle(1'($urandom_range(0, 3) != 0),
                           1'($urandom_range(0, 19) == 0),
                           1'($urandom_range(0, 39) == 0),
                           1'($urandom_range(0, 39) == 0),
                           6'($urandom),
                           1'($urandom_range(0, 9) == 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
